// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a sync/length/data frame on rx_line and writes 32-bit words into the
// instruction BRAM. It holds the CPU until a valid image is stored. BOOT_CHECKSUM_EN adds a checksum byte.
module uart_boot_loader #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic        clk_50,
  input  logic        rst_board,
  input  logic        rx_line,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned Div     = CLK_HZ / BAUD;
  localparam int unsigned HalfDiv = Div / 2;
  localparam int unsigned CntW    = $clog2(Div + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfDiv - 1);

  // ---------------------------------------------------------------- UART receiver
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld, frame_err;

  always_ff @(posedge clk_50 or negedge rst_board) begin
    if (!rst_board) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= rx_line;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == DivLast) begin
          byte_vld   = rx_s2_q;
          frame_err  = !rx_s2_q;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------- frame parser
  typedef enum logic [2:0] {
    StSync, StLenLo, StLenHi, StData, StCsum, StDone, StErr
  } state_e;

`ifdef BOOT_CHECKSUM_EN
  localparam state_e StTail = StCsum;
`else
  localparam state_e StTail = StDone;
`endif

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d, idx_q, idx_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     word_q, word_d, word_next;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic            cpu_hold_q, cpu_hold_d, load_done_q, load_done_d, load_err_q, load_err_d;
  logic [15:0]     len_full;
  logic            in_frame, timed_out;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == StLenHi) begin
      sum_d = '0;
    end else if (state_q == StData && byte_vld) begin
      sum_d = sum_q + rx_shift_q;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_board) begin
    if (!rst_board) sum_q <= '0;
    else            sum_q <= sum_d;
  end
`endif

  assign word_next = {rx_shift_q, word_q[31:8]};
  assign len_full  = {rx_shift_q, len_q[7:0]};
  assign in_frame  = state_q inside {StLenLo, StLenHi, StData, StCsum};
  assign timed_out = in_frame && (tmo_q >= TmoW'(TIMEOUT_CYC));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    load_err_d = load_err_q;

    if (!in_frame || byte_vld) tmo_d = '0;
    else if (!timed_out)       tmo_d = tmo_q + 1'b1;
    else                       tmo_d = tmo_q;

    unique case (state_q)
      StSync: begin
        if (byte_vld && rx_shift_q == 8'hA5) begin
          state_d    = StLenLo;
          load_err_d = 1'b0;
          idx_d      = '0;
        end
      end
      StLenLo: begin
        if (byte_vld) begin
          len_d   = {8'h00, rx_shift_q};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (byte_vld) begin
          len_d  = len_full;
          bcnt_d = '0;
          word_d = '0;
          if (len_full == 16'd0)                  state_d = StTail;
          else if (32'(len_full) > MAX_WORDS)      state_d = StErr;
          else                                     state_d = StData;
        end
      end
      StData: begin
        // idx has already advanced during the write cycle, so it equals N after the last word.
        if (wr_en_q) begin
          if (idx_q == len_q) state_d = StTail;
        end else if (byte_vld) begin
          word_d = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = word_next;
            wr_addr_d = {14'b0, idx_q, 2'b00};
            idx_d     = idx_q + 16'd1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      StCsum: begin
        if (byte_vld) state_d = (rx_shift_q == sum_q) ? StDone : StErr;
      end
`endif
      StDone:  state_d = StDone;
      StErr:   state_d = StSync;
      default: state_d = StSync;
    endcase

    // A byte landing in the same cycle as the timeout takes priority.
    if (in_frame && (frame_err || (timed_out && !byte_vld))) state_d = StErr;
    if (state_d == StErr) load_err_d = 1'b1;

    load_done_d = load_done_q | (state_d == StDone);
    cpu_hold_d  = ~load_done_d;
  end

  always_ff @(posedge clk_50 or negedge rst_board) begin
    if (!rst_board) begin
      state_q     <= StSync;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
